// File: rtl/cpu_ctrl_pkg.sv
// Shared constants and types for the multi-cycle controller.
// Opcodes, ALU codes, FSM states and instruction classes.
package cpu_ctrl_pkg;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;

    localparam logic [5:0] OPR_ADD = 6'b100000;
    localparam logic [5:0] OPR_SUB = 6'b100010;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_TRAP
    } state_t;

    typedef enum logic [1:0] {
        CLS_R,
        CLS_ADDI,
        CLS_BEQ,
        CLS_ILL
    } cls_t;

    // Map an opcode onto the class that steers EXEC and WB.
    function automatic cls_t classify(input logic [5:0] op);
        case (op)
            OP_R:    return CLS_R;
            OP_ADDI: return CLS_ADDI;
            OP_BEQ:  return CLS_BEQ;
            default: return CLS_ILL;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the sequencer and the datapath.
// The sequencer is the master; the datapath/memory side is the slave.
interface multicycle_ctrl_if;

    logic        start;
    logic        imem_req;
    logic        imem_ack;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        zero;
    logic        ir_load;
    logic        pc_en;
    logic        pc_src;
    logic        write;
    logic [5:0]  alu_funct;
    logic        rd_mux_s;
    logic        op2_mux_s;
    logic        busy;
    logic        trap;
    logic [15:0] retired;

    modport master (
        input  start, imem_ack, opcode, funct, zero,
        output imem_req, ir_load, pc_en, pc_src, write,
        output alu_funct, rd_mux_s, op2_mux_s,
        output busy, trap, retired
    );

    modport slave (
        output start, imem_ack, opcode, funct, zero,
        input  imem_req, ir_load, pc_en, pc_src, write,
        input  alu_funct, rd_mux_s, op2_mux_s,
        input  busy, trap, retired
    );

endinterface

// File: rtl/multicycle_ctrl_fetch_timer.sv
// Wait counter for instruction fetch.
// Flags the cycle in which the wait limit is reached.
module fetch_timer #(
    parameter int FETCH_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam logic [7:0] LAST = 8'(FETCH_TIMEOUT - 1);

    logic [7:0] count_q;

    // Count waiting cycles; clear has priority over increment.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            count_q <= '0;
        end else if (inc) begin
            count_q <= count_q + 8'd1;
        end
    end

    // This waiting cycle is the last one allowed.
    always_comb begin
        expired = inc && (count_q == LAST);
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer: fetch, decode, execute, writeback.
// Shares one ALU, one RF write port and one imem port.
module multicycle_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int FETCH_TIMEOUT = 15
) (
    input logic clk,
    input logic rst_n,
    multicycle_ctrl_if.master ctrl
);

    state_t      state_q;
    state_t      state_d;
    cls_t        cls_q;
    cls_t        cls_d;
    logic [5:0]  funct_q;
    logic [15:0] retired_q;

    logic        imem_req;
    logic        ir_load;
    logic        pc_en;
    logic        pc_src;
    logic        write;
    logic [5:0]  alu_funct;
    logic        rd_mux_s;
    logic        op2_mux_s;
    logic        busy;
    logic        trap;
    logic        retire;

    logic [5:0]  ex_alu;
    logic        ex_op2;

    logic        tmr_inc;
    logic        tmr_clear;
    logic        tmr_expired;

    fetch_timer #(
        .FETCH_TIMEOUT(FETCH_TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (tmr_clear),
        .inc    (tmr_inc),
        .expired(tmr_expired)
    );

    // Timer runs only while a fetch is outstanding.
    always_comb begin
        tmr_inc   = (state_q == S_FETCH) && !ctrl.imem_ack;
        tmr_clear = !tmr_inc;
    end

    // State plus the instruction class and funct captured in DECODE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cls_q   <= CLS_R;
            funct_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                cls_q   <= cls_d;
                funct_q <= ctrl.funct;
            end
        end
    end

    // Retired-instruction counter, wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            retired_q <= '0;
        end else if (retire) begin
            retired_q <= retired_q + 16'd1;
        end
    end

    // ALU setup shared by EXEC and WB so WB holds EXEC's values.
    always_comb begin
        ex_alu = '0;
        ex_op2 = 1'b0;
        unique case (cls_q)
            CLS_R:    ex_alu = funct_q;
            CLS_ADDI: begin
                ex_alu = OPR_ADD;
                ex_op2 = 1'b1;
            end
            CLS_BEQ:  ex_alu = OPR_SUB;
            default:  ex_alu = '0;
        endcase
    end

    // Next-state and control decode.
    always_comb begin
        state_d   = state_q;
        cls_d     = classify(ctrl.opcode);
        imem_req  = 1'b0;
        ir_load   = 1'b0;
        pc_en     = 1'b0;
        pc_src    = 1'b0;
        write     = 1'b0;
        alu_funct = '0;
        rd_mux_s  = 1'b0;
        op2_mux_s = 1'b0;
        busy      = 1'b0;
        trap      = 1'b0;
        retire    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (ctrl.start) state_d = S_FETCH;
            end
            S_FETCH: begin
                busy     = 1'b1;
                imem_req = 1'b1;
                if (ctrl.imem_ack) begin
                    ir_load = 1'b1;
                    state_d = S_DECODE;
                end else if (tmr_expired) begin
                    state_d = S_TRAP;
                end
            end
            S_DECODE: begin
                busy = 1'b1;
                if (cls_d == CLS_ILL) state_d = S_TRAP;
                else                  state_d = S_EXEC;
            end
            S_EXEC: begin
                busy      = 1'b1;
                alu_funct = ex_alu;
                op2_mux_s = ex_op2;
                unique case (cls_q)
                    CLS_BEQ: begin
                        pc_en   = 1'b1;
                        pc_src  = ctrl.zero;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    CLS_R, CLS_ADDI: state_d = S_WB;
                    default:         state_d = S_TRAP;
                endcase
            end
            S_WB: begin
                busy      = 1'b1;
                alu_funct = ex_alu;
                op2_mux_s = ex_op2;
                write     = 1'b1;
                rd_mux_s  = (cls_q == CLS_R);
                pc_en     = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_TRAP: begin
                trap = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign ctrl.imem_req  = imem_req;
    assign ctrl.ir_load   = ir_load;
    assign ctrl.pc_en     = pc_en;
    assign ctrl.pc_src    = pc_src;
    assign ctrl.write     = write;
    assign ctrl.alu_funct = alu_funct;
    assign ctrl.rd_mux_s  = rd_mux_s;
    assign ctrl.op2_mux_s = op2_mux_s;
    assign ctrl.busy      = busy;
    assign ctrl.trap      = trap;
    assign ctrl.retired   = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction cycle schedules
// built from the phase rules, compared against the DUT each cycle.
module tb_multicycle_ctrl;

    localparam logic [5:0] T_R    = 6'b000000;
    localparam logic [5:0] T_ADDI = 6'b001000;
    localparam logic [5:0] T_BEQ  = 6'b000100;
    localparam logic [5:0] T_ILL  = 6'b100011;
    localparam logic [5:0] A_ADD  = 6'b100000;
    localparam logic [5:0] A_SUB  = 6'b100010;
    localparam logic [5:0] Z6     = 6'd0;
    localparam logic       L0     = 1'b0;
    localparam logic       L1     = 1'b1;

    typedef logic [30:0] vec_t;

    typedef struct {
        logic       ack;
        logic       st;
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        vec_t       v;
    } ent_t;

    logic        clk;
    logic        rst_n;
    int          tests = 0;
    int          fails = 0;
    logic [15:0] exp_r = 16'd0;

    multicycle_ctrl_if ctrl_if ();

    multicycle_ctrl #(
        .FETCH_TIMEOUT(15)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .ctrl (ctrl_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t pk(
        input logic req, ild, pce, pcs, wr,
        input logic [5:0] alu,
        input logic rdm, op2, bsy, trp,
        input logic [15:0] ret
    );
        return {req, ild, pce, pcs, wr, alu,
                rdm, op2, bsy, trp, ret};
    endfunction

    function automatic vec_t observe();
        return {ctrl_if.imem_req, ctrl_if.ir_load,
                ctrl_if.pc_en, ctrl_if.pc_src,
                ctrl_if.write, ctrl_if.alu_funct,
                ctrl_if.rd_mux_s, ctrl_if.op2_mux_s,
                ctrl_if.busy, ctrl_if.trap,
                ctrl_if.retired};
    endfunction

    // Cycle with random don't-care inputs.
    function automatic ent_t nz(input vec_t v);
        ent_t e;
        e.ack = 1'($urandom);
        e.st  = 1'($urandom);
        e.op  = 6'($urandom);
        e.fn  = 6'($urandom);
        e.z   = 1'($urandom);
        e.v   = v;
        return e;
    endfunction

    // Expected cycles of one instruction, starting in FETCH.
    function automatic void build(
        input logic [5:0] op,
        input logic [5:0] fn,
        input logic z,
        input int dly,
        inout logic [15:0] r,
        inout ent_t q[$]
    );
        ent_t e;
        for (int k = 0; k <= dly; k++) begin
            e = nz(pk(L1, k == dly, L0, L0, L0, Z6,
                      L0, L0, L1, L0, r));
            e.ack = (k == dly);
            q.push_back(e);
        end
        e = nz(pk(L0, L0, L0, L0, L0, Z6,
                  L0, L0, L1, L0, r));
        e.op = op;
        e.fn = fn;
        q.push_back(e);
        if (op == T_R) begin
            q.push_back(nz(pk(L0, L0, L0, L0, L0, fn,
                              L0, L0, L1, L0, r)));
            q.push_back(nz(pk(L0, L0, L1, L0, L1, fn,
                              L1, L0, L1, L0, r)));
            r = r + 16'd1;
        end else if (op == T_ADDI) begin
            q.push_back(nz(pk(L0, L0, L0, L0, L0, A_ADD,
                              L0, L1, L1, L0, r)));
            q.push_back(nz(pk(L0, L0, L1, L0, L1, A_ADD,
                              L0, L1, L1, L0, r)));
            r = r + 16'd1;
        end else if (op == T_BEQ) begin
            e = nz(pk(L0, L0, L1, z, L0, A_SUB,
                      L0, L0, L1, L0, r));
            e.z = z;
            q.push_back(e);
            r = r + 16'd1;
        end else begin
            repeat (6)
                q.push_back(nz(pk(L0, L0, L0, L0, L0, Z6,
                                  L0, L0, L0, L1, r)));
        end
    endfunction

    task automatic exec_q(input ent_t q[$], output vec_t o[$]);
        o = {};
        foreach (q[i]) begin
            ctrl_if.imem_ack = q[i].ack;
            ctrl_if.start    = q[i].st;
            ctrl_if.opcode   = q[i].op;
            ctrl_if.funct    = q[i].fn;
            ctrl_if.zero     = q[i].z;
            #1;
            o.push_back(observe());
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst_n            = 1'b0;
        ctrl_if.start    = 1'b1;
        ctrl_if.imem_ack = 1'b1;
        repeat (2) @(negedge clk);
        rst_n            = 1'b1;
        ctrl_if.start    = 1'b0;
        ctrl_if.imem_ack = 1'b0;
        exp_r            = 16'd0;
    endtask

    task automatic go();
        ctrl_if.start    = 1'b1;
        ctrl_if.imem_ack = 1'b0;
        @(negedge clk);
        ctrl_if.start    = 1'b0;
    endtask

    task automatic test_reset();
        ent_t q[$];
        vec_t o[$];
        rst_n            = 1'b0;
        ctrl_if.start    = 1'b1;
        ctrl_if.imem_ack = 1'b1;
        repeat (2) begin
            @(negedge clk);
            #1;
            tests++;
            if (observe() !== 31'd0) begin
                fails++;
                $display("FAIL reset_out: got %h want 0",
                         observe());
            end
        end
        @(negedge clk);
        rst_n         = 1'b1;
        ctrl_if.start = 1'b0;
        repeat (2) begin
            @(negedge clk);
            #1;
            tests++;
            if (observe() !== 31'd0) begin
                fails++;
                $display("FAIL idle_out: got %h want 0",
                         observe());
            end
        end
        @(negedge clk);
        exp_r = 16'd0;
        go();
        build(T_R, A_ADD, 1'b0, 0, exp_r, q);
        exec_q(q, o);
        foreach (q[i]) begin
            tests++;
            if (o[i] !== q[i].v) begin
                fails++;
                $display("FAIL first_r[%0d]: got %h want %h",
                         i, o[i], q[i].v);
            end
        end
        ctrl_if.imem_ack = 1'b0;
        #1;
        tests++;
        if (ctrl_if.retired !== 16'd1) begin
            fails++;
            $display("FAIL retired_1: got %0d want 1",
                     ctrl_if.retired);
        end
    endtask

    task automatic test_addi_beq();
        ent_t q[$];
        vec_t o[$];
        logic [15:0] r0;
        r0 = exp_r;
        build(T_ADDI, 6'($urandom), 1'b0, 0, exp_r, q);
        build(T_BEQ, 6'($urandom), 1'b1, 0, exp_r, q);
        exec_q(q, o);
        foreach (q[i]) begin
            tests++;
            if (o[i] !== q[i].v) begin
                fails++;
                $display("FAIL addi_beq[%0d]: got %h want %h",
                         i, o[i], q[i].v);
            end
        end
        ctrl_if.imem_ack = 1'b0;
        #1;
        tests++;
        if (ctrl_if.retired !== r0 + 16'd2) begin
            fails++;
            $display("FAIL retired_2: got %0d want %0d",
                     ctrl_if.retired, r0 + 16'd2);
        end
    endtask

    task automatic test_fetch_stall();
        ent_t q[$];
        vec_t o[$];
        int nreq;
        int nild;
        build(T_R, 6'($urandom), 1'b0, 3, exp_r, q);
        build(T_ADDI, 6'($urandom), 1'b0, 14, exp_r, q);
        exec_q(q, o);
        foreach (q[i]) begin
            tests++;
            if (o[i] !== q[i].v) begin
                fails++;
                $display("FAIL stall[%0d]: got %h want %h",
                         i, o[i], q[i].v);
            end
        end
        nreq = 0;
        nild = 0;
        for (int i = 0; i < 6; i++) begin
            if (o[i][30]) nreq++;
            if (o[i][29]) nild++;
        end
        tests++;
        if (nreq != 4 || nild != 1) begin
            fails++;
            $display("FAIL stall_cnt: req %0d ild %0d want 4 1",
                     nreq, nild);
        end
    endtask

    task automatic test_random();
        ent_t q[$];
        vec_t o[$];
        logic [5:0] op;
        int dly;
        for (int n = 0; n < 30; n++) begin
            case ($urandom_range(0, 2))
                0:       op = T_R;
                1:       op = T_ADDI;
                default: op = T_BEQ;
            endcase
            if ($urandom_range(0, 9) == 0) dly = 14;
            else dly = int'($urandom_range(0, 4));
            build(op, 6'($urandom), 1'($urandom),
                  dly, exp_r, q);
        end
        exec_q(q, o);
        foreach (q[i]) begin
            tests++;
            if (o[i] !== q[i].v) begin
                fails++;
                $display("FAIL random[%0d]: got %h want %h",
                         i, o[i], q[i].v);
            end
        end
    endtask

    task automatic test_illegal();
        ent_t q[$];
        vec_t o[$];
        do_reset();
        go();
        build(T_ILL, 6'($urandom), 1'b0,
              int'($urandom_range(0, 3)), exp_r, q);
        exec_q(q, o);
        foreach (q[i]) begin
            tests++;
            if (o[i] !== q[i].v) begin
                fails++;
                $display("FAIL illegal[%0d]: got %h want %h",
                         i, o[i], q[i].v);
            end
        end
    endtask

    task automatic test_timeout();
        ent_t q[$];
        vec_t o[$];
        ent_t e;
        do_reset();
        go();
        repeat (15) begin
            e = nz(pk(L1, L0, L0, L0, L0, Z6,
                      L0, L0, L1, L0, exp_r));
            e.ack = 1'b0;
            q.push_back(e);
        end
        repeat (10)
            q.push_back(nz(pk(L0, L0, L0, L0, L0, Z6,
                              L0, L0, L0, L1, exp_r)));
        exec_q(q, o);
        foreach (q[i]) begin
            tests++;
            if (o[i] !== q[i].v) begin
                fails++;
                $display("FAIL timeout[%0d]: got %h want %h",
                         i, o[i], q[i].v);
            end
        end
        do_reset();
        #1;
        tests++;
        if (ctrl_if.trap !== 1'b0) begin
            fails++;
            $display("FAIL trap_clear: got %b want 0",
                     ctrl_if.trap);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        ent_t q[$];
        vec_t o[$];
        logic [15:0] r;
        do_reset();
        go();
        r = exp_r;
        build(T_R, 6'($urandom), 1'b0, 0, r, q);
        exec_q(q[0:2], o);
        ctrl_if.imem_ack = 1'b0;
        #1;
        tests++;
        if (ctrl_if.write !== 1'b1) begin
            fails++;
            $display("FAIL wb_write: got %b want 1",
                     ctrl_if.write);
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        tests++;
        if (observe() !== 31'd0) begin
            fails++;
            $display("FAIL rst_in_wb: got %h want 0",
                     observe());
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_r = 16'd0;
        go();
        q = {};
        build(T_BEQ, 6'($urandom), 1'b1, 1, r, q);
        exec_q(q[0:2], o);
        ctrl_if.zero = 1'b1;
        #1;
        tests++;
        if (ctrl_if.pc_en !== 1'b1) begin
            fails++;
            $display("FAIL ex_pc_en: got %b want 1",
                     ctrl_if.pc_en);
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        tests++;
        if (observe() !== 31'd0) begin
            fails++;
            $display("FAIL rst_in_ex: got %h want 0",
                     observe());
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_wrap();
        ent_t q[$];
        vec_t o[$];
        do_reset();
        force dut.retired_q = 16'hFFFF;
        #1;
        release dut.retired_q;
        tests++;
        if (ctrl_if.retired !== 16'hFFFF) begin
            fails++;
            $display("FAIL preload: got %h want ffff",
                     ctrl_if.retired);
        end
        go();
        exp_r = 16'hFFFF;
        build(T_BEQ, 6'($urandom), 1'b0, 0, exp_r, q);
        build(T_R, 6'($urandom), 1'b0, 0, exp_r, q);
        exec_q(q, o);
        foreach (q[i]) begin
            tests++;
            if (o[i] !== q[i].v) begin
                fails++;
                $display("FAIL wrap[%0d]: got %h want %h",
                         i, o[i], q[i].v);
            end
        end
    endtask

    initial begin
        rst_n            = 1'b0;
        ctrl_if.start    = 1'b0;
        ctrl_if.imem_ack = 1'b0;
        ctrl_if.opcode   = '0;
        ctrl_if.funct    = '0;
        ctrl_if.zero     = 1'b0;
        test_reset();
        test_addi_beq();
        test_fetch_stall();
        test_random();
        test_illegal();
        test_timeout();
        test_reset_mid();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
